// File: rtl/dot_acc_drain.sv
// Tile accumulator for signed dot16 partial results, with a one-entry
// valid/ready output register and a combinational stall back to the dot pipeline.
module dot_acc_drain #(
  parameter int IN_WIDTH  = 20,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 stall_out,
  output logic                 ovf_sticky,
  output logic                 drop_sticky
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic        [CNT_WIDTH-1:0] r_cnt;
  logic                        r_out_valid;
  logic signed [ACC_WIDTH-1:0] r_out_data;
  logic        [CNT_WIDTH-1:0] r_out_count;
  logic                        r_ovf;
  logic                        r_drop;

  logic                        w_beat;
  logic                        w_complete;
  logic                        w_consume;
  logic                        w_can_load;
  logic                        w_load;
  logic                        w_drop;
  logic                        w_acc_upd;
  logic                        w_acc_clr;
  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [ACC_WIDTH-1:0] w_base;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic                        w_ovf;
  logic        [CNT_WIDTH-1:0] w_newcnt;

  // Two's-complement overflow: equal operand signs, differing result sign.
  function automatic logic add_ovf(input logic signed [ACC_WIDTH-1:0] a,
                                   input logic signed [ACC_WIDTH-1:0] b,
                                   input logic signed [ACC_WIDTH-1:0] s);
    return (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic                 first);
    if (first)
      return CNT_WIDTH'(1);
    else if (&cnt)
      return cnt;
    else
      return cnt + CNT_WIDTH'(1);
  endfunction

  assign w_beat     = ena & in_valid;
  assign w_complete = w_beat & in_last;
  assign w_consume  = r_out_valid & out_ready;
  assign w_can_load = ~r_out_valid | out_ready;
  assign w_load     = w_complete & w_can_load;
  assign w_drop     = w_complete & ~w_can_load;

  assign w_ext    = ACC_WIDTH'($signed(in_data));
  assign w_base   = (r_state == IDLE) ? '0 : r_acc;
  assign w_sum    = w_base + w_ext;
  assign w_ovf    = add_ovf(w_base, w_ext, w_sum);
  assign w_newcnt = sat_inc(r_cnt, r_state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_beat && !in_last) w_next_state = ACCUM;
      ACCUM:   if (w_complete)         w_next_state = IDLE;
      default:                         w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_acc_upd = 1'b0;
    w_acc_clr = 1'b0;
    case (r_state)
      IDLE, ACCUM: begin
        w_acc_upd = w_beat & ~in_last;
        w_acc_clr = w_complete;
      end
      default: w_acc_clr = 1'b1;
    endcase
  end

  // Accumulate stage: partial sum and beat count for the tile in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_acc_clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_acc_upd) begin
      r_acc <= w_sum;
      r_cnt <= w_newcnt;
    end
  end

  // Output stage: a blocked completion is dropped, leaving the held tile intact.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sum;
      r_out_count <= w_newcnt;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovf  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      if (w_beat && w_ovf) r_ovf  <= 1'b1;
      if (w_drop)          r_drop <= 1'b1;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_count   = r_out_count;
  assign stall_out   = r_out_valid & ~out_ready;
  assign ovf_sticky  = r_ovf;
  assign drop_sticky = r_drop;

endmodule

// File: tb/tb_dot_acc_drain.sv
// Randomized and directed bench for dot_acc_drain: a 32-bit/16-bit-count instance
// and a 20-bit/4-bit-count instance share one stimulus stream and one tile model.
module tb_dot_acc_drain;

  logic        clk = 1'b0;
  logic        rst, ena, in_valid, in_last, out_ready;
  logic [19:0] in_data;

  logic        a_ov, a_stall, a_ovf, a_drop;
  logic [31:0] a_od;
  logic [15:0] a_oc;
  logic        b_ov, b_stall, b_ovf, b_drop;
  logic [19:0] b_od;
  logic [3:0]  b_oc;

  int total = 0;
  int bad   = 0;

  // Reference model: tile-level state with plain integer arithmetic.
  bit     m_busy;
  longint m_acc32, m_acc20;
  int     m_n;
  bit     m_ov;
  longint m_od32, m_od20;
  int     m_oc16, m_oc4;
  bit     m_ovf32, m_ovf20, m_drop;

  always #5 clk = ~clk;

  dot_acc_drain #(.IN_WIDTH(20), .ACC_WIDTH(32), .CNT_WIDTH(16)) u_a (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od),
    .out_count(a_oc), .stall_out(a_stall), .ovf_sticky(a_ovf), .drop_sticky(a_drop)
  );

  dot_acc_drain #(.IN_WIDTH(20), .ACC_WIDTH(20), .CNT_WIDTH(4)) u_b (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od),
    .out_count(b_oc), .stall_out(b_stall), .ovf_sticky(b_ovf), .drop_sticky(b_drop)
  );

  function automatic longint wrapw(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v & (m - 1);
    if (r >= (m >> 1)) r = r - m;
    return r;
  endfunction

  // Drive one cycle, advance the model at the edge, return 1 time unit later.
  task automatic cyc(input bit r, input bit e, input bit v, input int d,
                     input bit l, input bit rdy);
    bit     cons, loaded;
    longint x, t32, t20;
    int     n;
    rst = r; ena = e; in_valid = v; in_data = 20'(d); in_last = l; out_ready = rdy;
    @(posedge clk);
    if (!r) begin
      m_busy = 0; m_acc32 = 0; m_acc20 = 0; m_n = 0;
      m_ov = 0; m_od32 = 0; m_od20 = 0; m_oc16 = 0; m_oc4 = 0;
      m_ovf32 = 0; m_ovf20 = 0; m_drop = 0;
    end else begin
      cons   = m_ov && rdy;
      loaded = 0;
      if (e && v) begin
        x   = wrapw(longint'(d), 20);
        t32 = (m_busy ? m_acc32 : 0) + x;
        t20 = (m_busy ? m_acc20 : 0) + x;
        if (t32 != wrapw(t32, 32)) m_ovf32 = 1;
        if (t20 != wrapw(t20, 20)) m_ovf20 = 1;
        t32 = wrapw(t32, 32);
        t20 = wrapw(t20, 20);
        n   = m_busy ? m_n + 1 : 1;
        if (l) begin
          if (!m_ov || rdy) begin
            m_od32 = t32; m_od20 = t20;
            m_oc16 = (n > 65535) ? 65535 : n;
            m_oc4  = (n > 15) ? 15 : n;
            m_ov   = 1;
            loaded = 1;
          end else begin
            m_drop = 1;
          end
          m_busy = 0; m_acc32 = 0; m_acc20 = 0; m_n = 0;
        end else begin
          m_busy = 1; m_acc32 = t32; m_acc20 = t20; m_n = n;
        end
      end
      if (cons && !loaded) m_ov = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 77, 1, 1);
    total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", a_ov); end
    total++; if (a_od !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", a_od); end
    total++; if (a_oc !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", a_oc); end
    total++; if ({a_ovf, a_drop, a_stall, b_ovf, b_drop} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {a_ovf, a_drop, a_stall, b_ovf, b_drop});
    end
  endtask

  task automatic test_single_beat();
    cyc(1, 1, 1, -5, 1, 1);
    total++; if (a_ov !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", a_ov); end
    total++; if (a_od !== 32'hFFFF_FFFB) begin bad++; $display("FAIL single_data got=%h exp=fffffffb", a_od); end
    total++; if (a_oc !== 16'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", a_oc); end
    cyc(1, 1, 1, 4, 1, 1);
    total++; if (a_od !== 32'd4 || a_oc !== 16'd1) begin
      bad++; $display("FAIL single_idle_after got=%h/%0d exp=4/1", a_od, a_oc);
    end
    cyc(1, 0, 0, 0, 0, 1);
    total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL single_consume got=%b exp=0", a_ov); end
  endtask

  task automatic test_four_beat();
    cyc(1, 1, 1, 100, 0, 0);
    cyc(1, 1, 1, 200, 0, 0);
    cyc(1, 0, 1, 999, 1, 0);
    total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL gated_no_effect got=%b exp=0", a_ov); end
    cyc(1, 1, 0, 555, 1, 0);
    cyc(1, 1, 1, -50, 0, 0);
    cyc(1, 1, 1, 7, 1, 0);
    total++; if (a_ov !== 1'b1 || a_od !== 32'd257) begin
      bad++; $display("FAIL four_data got=%b/%0d exp=1/257", a_ov, a_od);
    end
    total++; if (a_oc !== 16'd4) begin bad++; $display("FAIL four_count got=%0d exp=4", a_oc); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      total++; if (a_stall !== 1'b1 || a_od !== 32'd257 || a_ov !== 1'b1) begin
        bad++; $display("FAIL bp_hold[%0d] stall=%b valid=%b data=%0d exp=1/1/257", i, a_stall, a_ov, a_od);
      end
    end
    total++; if (a_drop !== 1'b0) begin bad++; $display("FAIL bp_predrop got=%b exp=0", a_drop); end
    cyc(1, 1, 1, 9, 1, 0);
    total++; if (a_drop !== 1'b1 || a_od !== 32'd257 || a_oc !== 16'd4) begin
      bad++; $display("FAIL bp_drop drop=%b data=%0d cnt=%0d exp=1/257/4", a_drop, a_od, a_oc);
    end
    cyc(1, 1, 1, 11, 0, 1);
    total++; if (a_ov !== 1'b0 || a_od !== 32'd257) begin
      bad++; $display("FAIL bp_release valid=%b data=%0d exp=0/257", a_ov, a_od);
    end
    cyc(1, 1, 1, 246, 1, 0);
    total++; if (a_od !== 32'd257 || a_oc !== 16'd2) begin
      bad++; $display("FAIL bp_after_drop data=%0d cnt=%0d exp=257/2", a_od, a_oc);
    end
  endtask

  task automatic test_simultaneous();
    cyc(1, 1, 1, 3, 1, 1);
    total++; if (a_ov !== 1'b1 || a_od !== 32'd3 || a_oc !== 16'd1) begin
      bad++; $display("FAIL simul_load valid=%b data=%0d cnt=%0d exp=1/3/1", a_ov, a_od, a_oc);
    end
    total++; if (a_drop !== 1'b1) begin bad++; $display("FAIL simul_drop_kept got=%b exp=1", a_drop); end
    cyc(1, 0, 0, 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 1, 1, i * 1000 - 3000, 1, 1);
      total++; if (a_ov !== 1'b1 || a_od !== 32'(i * 1000 - 3000) || a_oc !== 16'd1) begin
        bad++; $display("FAIL b2b[%0d] valid=%b data=%h cnt=%0d exp=1/%h/1", i, a_ov, a_od, a_oc, 32'(i * 1000 - 3000));
      end
    end
    cyc(1, 0, 0, 0, 0, 1);
  endtask

  task automatic test_overflow();
    cyc(1, 1, 1, 524287, 0, 1);
    cyc(1, 1, 1, 1, 1, 1);
    total++; if (b_od !== 20'h80000 || b_ovf !== 1'b1) begin
      bad++; $display("FAIL ovf20 data=%h ovf=%b exp=80000/1", b_od, b_ovf);
    end
    total++; if (a_od !== 32'h0008_0000 || a_ovf !== 1'b0) begin
      bad++; $display("FAIL ovf32_none data=%h ovf=%b exp=00080000/0", a_od, a_ovf);
    end
    cyc(1, 1, 1, 2, 1, 1);
    total++; if (b_od !== 20'd2 || b_ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky data=%h ovf=%b exp=2/1", b_od, b_ovf);
    end
    cyc(1, 1, 1, -524288, 0, 1);
    cyc(1, 1, 1, -1, 1, 1);
    total++; if (b_od !== 20'h7FFFF || a_od !== 32'hFFF7_FFFF) begin
      bad++; $display("FAIL ovf_neg b=%h a=%h exp=7ffff/fff7ffff", b_od, a_od);
    end
    cyc(1, 0, 0, 0, 0, 1);
  endtask

  task automatic test_count_sat();
    for (int i = 0; i < 19; i++) cyc(1, 1, 1, 1, 0, 1);
    cyc(1, 1, 1, 1, 1, 1);
    total++; if (b_oc !== 4'd15 || a_oc !== 16'd20 || b_od !== 20'd20) begin
      bad++; $display("FAIL count_sat b_cnt=%0d a_cnt=%0d b_data=%0d exp=15/20/20", b_oc, a_oc, b_od);
    end
    cyc(1, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    cyc(1, 1, 1, 10, 0, 1);
    cyc(1, 1, 1, 20, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    total++; if ({a_ov, a_ovf, a_drop, b_ovf, b_drop} !== 5'b0 || a_od !== 32'd0) begin
      bad++; $display("FAIL rstmid_flags got=%b data=%0d exp=00000/0", {a_ov, a_ovf, a_drop, b_ovf, b_drop}, a_od);
    end
    cyc(1, 1, 1, 5, 1, 1);
    total++; if (a_ov !== 1'b1 || a_od !== 32'd5 || a_oc !== 16'd1) begin
      bad++; $display("FAIL rstmid_tile valid=%b data=%0d cnt=%0d exp=1/5/1", a_ov, a_od, a_oc);
    end
    cyc(1, 0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit r, e, v, l, rdy;
    int d;
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(0, 299) != 0);
      e   = ($urandom_range(0, 9) < 8);
      v   = ($urandom_range(0, 9) < 7);
      l   = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 3))
        0:       d = 524287;
        1:       d = -524288;
        default: d = int'(wrapw(longint'($urandom), 20));
      endcase
      cyc(r, e, v, d, l, rdy);
      total++;
      if (a_ov !== m_ov || a_od !== 32'(m_od32) || a_oc !== 16'(m_oc16) ||
          a_stall !== (m_ov & ~rdy) || a_ovf !== m_ovf32 || a_drop !== m_drop) begin
        bad++;
        $display("FAIL rand_a[%0d] v=%b d=%h c=%0d s=%b o=%b dr=%b exp v=%b d=%h c=%0d s=%b o=%b dr=%b",
                 i, a_ov, a_od, a_oc, a_stall, a_ovf, a_drop,
                 m_ov, 32'(m_od32), m_oc16, m_ov & ~rdy, m_ovf32, m_drop);
      end
      total++;
      if (b_ov !== m_ov || b_od !== 20'(m_od20) || b_oc !== 4'(m_oc4) ||
          b_stall !== (m_ov & ~rdy) || b_ovf !== m_ovf20 || b_drop !== m_drop) begin
        bad++;
        $display("FAIL rand_b[%0d] v=%b d=%h c=%0d s=%b o=%b dr=%b exp v=%b d=%h c=%0d o=%b dr=%b",
                 i, b_ov, b_od, b_oc, b_stall, b_ovf, b_drop,
                 m_ov, 20'(m_od20), m_oc4, m_ovf20, m_drop);
      end
    end
  endtask

  initial begin
    rst = 1'b0; ena = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single_beat();
    test_four_beat();
    test_backpressure();
    test_simultaneous();
    test_back_to_back();
    test_overflow();
    test_count_sat();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot_acc_drain.md
Name: dot_acc_drain

Overview:
- Consumes the signed dot16 partial results produced by the PE dot-product datapath.
- Accumulates one tile's worth of partial results (K/16 beats, delimited by in_last) into a wide signed accumulator.
- Presents each finished tile sum on a one-entry valid/ready output register toward the PE result drain/writeback path.
- Raises backpressure toward the dot pipeline's global enable.

Parameters:
- IN_WIDTH, 20, width of the signed dot16 result (DATA_WIDTH*2+4 for DATA_WIDTH=8).
- ACC_WIDTH, 32, width of the signed accumulator and out_data; must be >= IN_WIDTH.
- CNT_WIDTH, 16, width of the beat counter and out_count.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-low reset.
- ena  input  1  global pipeline enable, shared with the dot pipeline; qualifies input beats.
- in_valid  input  1  in_data is a valid partial result this cycle.
- in_data  input  IN_WIDTH  signed partial dot product.
- in_last  input  1  final partial of the current tile; meaningful only with in_valid.
- out_valid  output  1  out_data/out_count hold a finished tile.
- out_ready  input  1  downstream accepts the output when out_valid=1.
- out_data  output  ACC_WIDTH  signed tile sum.
- out_count  output  CNT_WIDTH  number of beats summed into out_data (saturating).
- stall_out  output  1  combinational out_valid & ~out_ready; upstream must hold ena low while it is high.
- ovf_sticky  output  1  signed accumulate overflow has occurred since reset.
- drop_sticky  output  1  a tile completed while the output register was blocked since reset.

Behaviour:
- Reset (rst=0 at a clk edge):
  - acc=0, cnt=0, state=IDLE.
  - out_valid=0, out_data=0, out_count=0.
  - ovf_sticky=0, drop_sticky=0.
  - Reset mid-tile discards the partial sum. Reset with out_valid=1 discards the pending output.
- Beat: a cycle with rst=1, ena=1 and in_valid=1. Cycles with ena=0 or in_valid=0 leave acc, cnt and state unchanged.
- Arithmetic:
  - in_data is sign-extended to ACC_WIDTH.
  - sum = (state==IDLE ? 0 : acc) + sext(in_data), computed modulo 2^ACC_WIDTH (wraps, no saturation).
  - Signed overflow is set when both operands have equal sign and the result sign differs. Overflow sets ovf_sticky; it is never cleared except by reset.
- Beat count: newcnt = (state==IDLE ? 1 : cnt+1), saturating at 2^CNT_WIDTH-1.
- State machine (IDLE = no partial held, ACCUM = partial held in acc):
  - IDLE, beat with in_last=0: acc<=sum, cnt<=newcnt, go to ACCUM.
  - IDLE or ACCUM, beat with in_last=1: the tile completes. acc<=0, cnt<=0, go to IDLE. The result is offered to the output register.
  - ACCUM, beat with in_last=0: acc<=sum, cnt<=newcnt, stay in ACCUM.
- Output register:
  - Handshake is independent of ena. The output is consumed on any cycle with out_valid & out_ready.
  - A completing tile loads out_data<=sum, out_count<=newcnt, out_valid<=1 when out_valid==0 or out_ready==1 in that cycle. This covers a simultaneous consume and load: the register is reloaded with no bubble and out_valid stays 1.
  - Consume with no completing tile: out_valid<=0. out_data and out_count keep their last values.
  - Completion while out_valid=1 and out_ready=0 is a protocol violation. The new tile is dropped, the output register is unchanged, drop_sticky<=1, and the accumulator still clears to IDLE.
  - out_valid and out_data are stable while out_valid=1 and out_ready=0.
- Latency: out_valid rises on the clock edge that samples the last beat, i.e. one cycle after the last beat is presented. Sustained throughput is one beat per cycle, including back-to-back single-beat tiles when out_ready=1.
- stall_out: purely combinational, with no dependency on in_valid or ena.

Test Plan:
- Single-beat tile: in_data=-5 (0xFFFFB), in_last=1, out_ready=1 -> next cycle out_valid=1, out_data=0xFFFFFFFB, out_count=1, state IDLE.
- Four-beat tile: 100, 200, -50, 7 (in_last on 7), with ena=0 and in_valid=1 inserted between 200 and -50 -> out_data=257, out_count=4. The gated cycle has no effect.
- Backpressure: tile sum 257 pending with out_ready=0 -> stall_out=1, out_data holds 257 for 5 cycles. A second tile (9, last) completing while blocked -> drop_sticky=1, out_data still 257. Then out_ready=1 -> out_valid=0 next cycle.
- Simultaneous consume and load: out_valid=1 with 257, out_ready=1 in the same cycle as a last beat of 3 -> out_valid stays 1, out_data=3, out_count=1, drop_sticky unchanged.
- Overflow (ACC_WIDTH=20): beats 524287 then 1 (last) -> out_data=0x80000 (-524288), ovf_sticky=1. ovf_sticky is still 1 after the next clean tile.
- Reset mid-tile: two beats 10, 20, then rst=0 for 1 cycle, then beat 5 (last) -> out_data=5, out_count=1. Every flag is 0 after reset.
